// File: rtl/program_loader.sv
// Host-side program loader: parses a framed byte stream into single-cycle
// instruction/data memory writes on the CPU load port and controls the CPU reset.
module program_loader #(
   parameter int IMEM_DEPTH = 32,
   parameter int DMEM_DEPTH = 16,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] cpu_input,
   output logic [ADDR_W-1:0] load_address,
   output logic              load,
   output logic              is_instruction,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_RUN,
      S_ERROR
   } state_t;

   localparam int SUM_W = DATA_W + 1;
   localparam logic [DATA_W-1:0] CMD_RUN  = DATA_W'('hFF);
   localparam logic [DATA_W-1:0] CMD_HALT = DATA_W'('hFE);
   localparam logic [SUM_W-1:0]  IMEM_LIMIT = SUM_W'(IMEM_DEPTH);
   localparam logic [SUM_W-1:0]  DMEM_LIMIT = SUM_W'(DMEM_DEPTH);

   state_t             state;
   logic               target;
   logic [ADDR_W-1:0]  addr;
   logic [DATA_W-1:0]  remaining;

   logic               accept;
   logic [SUM_W-1:0]   end_addr;
   logic               hdr_bad;
   logic               len_bad;

   // NOTE: helper terms are continuous assigns; all state lives in the single
   // always_ff below and is updated only with non-blocking assignments.
   assign accept = in_valid && in_ready;

   // One bit wider than the byte so start+L can never wrap past the limit.
   assign end_addr = SUM_W'(addr) + SUM_W'(in_data);

   assign hdr_bad = (in_data[DATA_W-2:ADDR_W] != '0) ||
                    (!in_data[DATA_W-1] &&
                     (SUM_W'(in_data[ADDR_W-1:0]) >= DMEM_LIMIT));

   assign len_bad = (in_data == '0) ||
                    (end_addr > (target ? IMEM_LIMIT : DMEM_LIMIT));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         load           <= 1'b0;
         cpu_input      <= '0;
         load_address   <= '0;
         is_instruction <= 1'b0;
         cpu_reset      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         in_ready       <= 1'b0;
         target         <= 1'b0;
         addr           <= '0;
         remaining      <= '0;
      end else begin
         load     <= 1'b0;
         in_ready <= (state != S_ERROR);

         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (in_data == CMD_RUN) begin
                     state     <= S_RUN;
                     cpu_reset <= 1'b0;
                     done      <= 1'b1;
                  end else if (in_data == CMD_HALT) begin
                     state <= S_IDLE;
                  end else if (hdr_bad) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                  end else begin
                     state  <= S_LEN;
                     target <= in_data[DATA_W-1];
                     addr   <= in_data[ADDR_W-1:0];
                     busy   <= 1'b1;
                  end
               end
            end

            S_LEN: begin
               if (accept) begin
                  if (len_bad) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     state     <= S_PAYLOAD;
                     remaining <= in_data;
                  end
               end
            end

            S_PAYLOAD: begin
               if (accept) begin
                  load           <= 1'b1;
                  cpu_input      <= in_data;
                  load_address   <= addr;
                  is_instruction <= target;
                  addr           <= addr + 1'b1;
                  remaining      <= remaining - 1'b1;
                  if (remaining == DATA_W'(1)) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            S_RUN: begin
               // Anything but HALT is swallowed while the CPU runs.
               if (accept && (in_data == CMD_HALT)) begin
                  state     <= S_IDLE;
                  cpu_reset <= 1'b1;
                  done      <= 1'b0;
               end
            end

            S_ERROR: begin
               in_ready  <= 1'b0;
               error     <= 1'b1;
               cpu_reset <= 1'b1;
               busy      <= 1'b0;
               done      <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Host-side loader that drives the CPU's unified load interface: cpu_input, load_address, load and is_instruction.
- Accepts a framed byte stream over a valid/ready handshake.
- Writes instruction and data memories with single-cycle load pulses.
- Holds the CPU in reset while loading and releases it on a RUN command.
- Sits between the host/link and the CPU top level.

Parameters:
IMEM_DEPTH, 32, instruction memory entries (legal addresses 0..31)
DMEM_DEPTH, 16, data memory entries (legal addresses 0..15)
ADDR_W, 5, load_address width
DATA_W, 8, byte width of the stream and cpu_input

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte; transfer when in_valid&&in_ready
cpu_input  out  8  byte to CPU load port
load_address  out  5  target address
load  out  1  one-cycle write strobe to CPU
is_instruction  out  1  1=instruction memory, 0=data memory
cpu_reset  out  1  active-high reset to CPU, held while not running
busy  out  1  frame in progress (LEN or PAYLOAD)
done  out  1  CPU released (RUN state)
error  out  1  sticky frame error

Behaviour:
- Reset (reset==0 at clk edge) forces state IDLE and these outputs: load=0, cpu_input=0, load_address=0, is_instruction=0, cpu_reset=1, busy=0, done=0, error=0, in_ready=0. in_ready goes to 1 on the first cycle after reset deasserts.
- Reset mid-frame aborts the frame. Any partially loaded memory contents stay as written.
- Frame format: HEADER, LEN, then LEN payload bytes.
  - HEADER[7] = target (1=instruction, 0=data). HEADER[6:5] must be 00. HEADER[4:0] = start address.
  - Command headers: 0xFF = RUN, 0xFE = HALT.
- States:
  - IDLE: in_ready=1.
    - Command 0xFF goes to RUN.
    - Command 0xFE is consumed with no effect.
    - A legal header latches target and start address, then goes to LEN.
    - Header with [6:5]!=00 (other than FE/FF) goes to ERROR.
    - Data header with HEADER[4]=1 goes to ERROR.
  - LEN: in_ready=1. Latch L = in_data.
    - L==0 goes to ERROR.
    - start+L > depth of the target (IMEM_DEPTH or DMEM_DEPTH) goes to ERROR.
    - Otherwise load remaining=L and go to PAYLOAD. Compute the sum at 9 bits so there is no wrap.
  - PAYLOAD: in_ready=1. Each accepted byte at edge t produces, in cycle t+1 for exactly one cycle:
    - load=1, cpu_input=byte, load_address=current address, is_instruction=target.
    - Then address increments and remaining decrements.
    - Accepting the last byte (remaining==1) returns to IDLE.
    - Back-to-back accepted bytes give back-to-back load pulses with consecutive addresses.
    - in_valid low inserts gaps; load=0 in gap cycles.
    - Address never wraps, because the bound is checked in LEN.
  - RUN: cpu_reset=0 and done=1, both from the cycle after 0xFF is accepted. in_ready=1.
    - Byte 0xFE: cpu_reset=1 and done=0 from the next cycle, go to IDLE.
    - Any other byte is consumed and discarded; load stays 0.
  - ERROR: in_ready=0, error=1, cpu_reset=1, load=0. Exit only via reset.
- Output rules:
  - busy=1 exactly when state is LEN or PAYLOAD.
  - load is never asserted outside the cycle following a payload acceptance.
  - cpu_reset is 1 in every state except RUN.
- All outputs are registered. Latency from input byte to load pulse is 1 cycle.
- No byte is lost or duplicated under arbitrary in_valid patterns.

Test Plan:
1. Reset, then stream 0x83,0x03,0xA1,0xB2,0xC3 with in_valid held high -> load high on 3 consecutive cycles, addresses 3,4,5, cpu_input A1,B2,C3, is_instruction=1, cpu_reset=1, busy high until the last byte.
2. Data frame 0x0E,0x02,0x11,0x22 with in_valid toggling every other cycle -> two isolated load pulses, address 14 then 15, is_instruction=0, load low in gap cycles.
3. Data header 0x0F,0x02 (15+2>16) -> error=1 next cycle, in_ready=0, no load pulses. Further bytes are ignored until reset, after which error=0 and in_ready=1.
4. Stream 0xFF -> cpu_reset falls and done rises on the next cycle. Then 0x12 -> discarded, no load. Then 0xFE -> cpu_reset=1, done=0, state IDLE.
5. Header 0x80, LEN 0x00 -> ERROR. Separately, header 0x40 -> ERROR. Separately, data header 0x10 -> ERROR.
6. Assert reset mid-PAYLOAD after 1 of 4 bytes -> all outputs return to reset values. A new frame 0x80,0x01,0x55 then loads address 0 with 0x55.
